// File: rtl/numgen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : numgen_pkg
// Description : Shared types and constants for number_value_generator.
//               numgen_state_t - fill controller state
//               LFSR_TAPS      - Galois feedback mask of the 16-bit LFSR
//               digit_t        - one displayed digit (4 bits)
// Revision    : 1.0 - initial release
// ============================================================================
package numgen_pkg;

    typedef enum logic [1:0] {
        FILL_ALL = 2'd0,
        FILL_ONE = 2'd1,
        IDLE     = 2'd2
    } numgen_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [3:0] digit_t;

endpackage
`default_nettype wire

// File: rtl/numgen_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : numgen_lfsr
// Description : Free-running 16-bit Galois LFSR. Steps on every clock edge
//               outside reset. A zero seed would lock the register at zero,
//               so it is replaced by 16'h0001.
// Ports       : clk_i   - clock
//               reset_i - asynchronous active-high reset (loads the seed)
//               state_o - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module numgen_lfsr
    import numgen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [15:0] state_o
);

    localparam logic [15:0] SAFE_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_q <= SAFE_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/number_value_generator.sv
`default_nettype none
// ============================================================================
// Module      : number_value_generator
// Description : Produces the digit values shown by the number sprites. Fills
//               every slot from a free-running LFSR after reset or on
//               refreshReq, and re-rolls a single slot on hitValid.
//               Optional feature macro: NUMGEN_UNIQUE_EN - when defined, a
//               candidate equal to the digit in the previous slot (wrapping)
//               is rejected; the fallback draw ignores this rule.
// Ports       : clk         - clock
//               reset       - asynchronous active-high reset
//               refreshReq  - pulse, re-roll all slots
//               hitValid    - pulse, re-roll slot hitIndex
//               hitIndex    - slot that was hit (>= NUM_SLOTS ignored)
//               digits      - current digit per slot
//               digitsValid - every slot holds a drawn value
//               busy        - a fill is in progress
//               hitDropped  - pulse when a pending hit is overwritten
// Revision    : 1.0 - initial release
// ============================================================================
module number_value_generator
    import numgen_pkg::*;
#(
    parameter int          NUM_SLOTS = 12,
    parameter int          MAX_DIGIT = 9,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_RETRY = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      refreshReq,
    input  logic                      hitValid,
    input  logic [3:0]                hitIndex,
    output logic [NUM_SLOTS-1:0][3:0] digits,
    output logic                      digitsValid,
    output logic                      busy,
    output logic                      hitDropped
);

    localparam int                 RETRY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam digit_t             DIGIT_LIMIT = digit_t'(MAX_DIGIT);
    localparam logic [4:0]         SLOT_COUNT  = 5'(NUM_SLOTS);
    localparam logic [3:0]         LAST_IDX    = 4'(NUM_SLOTS - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    numgen_state_t                state_q, state_d;
    logic [3:0]                   idx_q, idx_d;
    logic [RETRY_W-1:0]           retry_q, retry_d;
    logic [NUM_SLOTS-1:0][3:0]    digits_q, digits_d;
    logic                         valid_q, valid_d;
    logic                         busy_q, busy_d;
    logic                         drop_q, drop_d;
    logic                         pend_ref_q, pend_ref_d;
    logic                         pend_hit_q, pend_hit_d;
    logic [3:0]                   pend_idx_q, pend_idx_d;

    // ------------------------------------------------------------------
    // Candidate source and acceptance
    // ------------------------------------------------------------------
    logic [15:0] w_lfsr;
    digit_t      w_cand;
    logic        w_unused_lfsr;
    logic        w_unique_ok;
    logic        w_accept;
    logic        w_hit_ok;
    logic        w_write;

    numgen_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk),
        .reset_i (reset),
        .state_o (w_lfsr)
    );

    // Only the low nibble is drawn; the upper bits only feed the sequence.
    assign w_cand        = w_lfsr[3:0];
    assign w_unused_lfsr = ^w_lfsr[15:4];

`ifdef NUMGEN_UNIQUE_EN
    logic [3:0] w_prev_idx;
    digit_t     w_prev_digit;

    // Neighbour on the left, wrapping slot 0 around to the last slot.
    assign w_prev_idx   = (idx_q == 4'd0) ? LAST_IDX : (idx_q - 4'd1);
    assign w_prev_digit = digits_q[w_prev_idx];
    assign w_unique_ok  = (w_cand != w_prev_digit);
`else
    assign w_unique_ok  = 1'b1;
`endif

    assign w_accept = (w_cand <= DIGIT_LIMIT) && w_unique_ok;
    assign w_hit_ok = hitValid && ({1'b0, hitIndex} < SLOT_COUNT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        digits_d   = digits_q;
        valid_d    = valid_q;
        drop_d     = 1'b0;
        pend_ref_d = pend_ref_q;
        pend_hit_d = pend_hit_q;
        pend_idx_d = pend_idx_q;
        w_write    = 1'b0;

        unique case (state_q)
            FILL_ALL, FILL_ONE: begin
                // Fallback takes precedence so a slot never waits more than
                // MAX_RETRY+1 cycles; the mask keeps it a legal digit.
                if (retry_q == RETRY_LIMIT) begin
                    digits_d[idx_q] = w_cand & 4'h7;
                    retry_d         = '0;
                    w_write         = 1'b1;
                end else if (w_accept) begin
                    digits_d[idx_q] = w_cand;
                    retry_d         = '0;
                    w_write         = 1'b1;
                end else begin
                    retry_d = retry_q + 1'b1;
                end

                if (w_write) begin
                    if (state_q == FILL_ALL) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            valid_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end

                // A full fill covers any request, so only a single-slot fill
                // has to remember what arrived meanwhile. Refresh beats a
                // simultaneous hit, which is then dropped silently.
                if (state_q == FILL_ONE) begin
                    if (refreshReq) begin
                        pend_ref_d = 1'b1;
                    end else if (w_hit_ok) begin
                        drop_d     = pend_hit_q;
                        pend_hit_d = 1'b1;
                        pend_idx_d = hitIndex;
                    end
                end
            end

            IDLE: begin
                if (pend_ref_q || refreshReq) begin
                    state_d    = FILL_ALL;
                    idx_d      = 4'd0;
                    retry_d    = '0;
                    valid_d    = 1'b0;
                    pend_ref_d = 1'b0;
                    pend_hit_d = 1'b0;
                end else if (pend_hit_q) begin
                    // The pending slot is consumed now, so a hit arriving in
                    // this same cycle takes its place without a drop.
                    state_d    = FILL_ONE;
                    idx_d      = pend_idx_q;
                    pend_hit_d = w_hit_ok;
                    if (w_hit_ok) begin
                        pend_idx_d = hitIndex;
                    end
                end else if (w_hit_ok) begin
                    state_d = FILL_ONE;
                    idx_d   = hitIndex;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL_ALL;
            idx_q      <= 4'd0;
            retry_q    <= '0;
            digits_q   <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
            drop_q     <= 1'b0;
            pend_ref_q <= 1'b0;
            pend_hit_q <= 1'b0;
            pend_idx_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            pend_ref_q <= pend_ref_d;
            pend_hit_q <= pend_hit_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    assign digits      = digits_q;
    assign digitsValid = valid_q;
    assign busy        = busy_q;
    assign hitDropped  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_number_value_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_number_value_generator
// Description : Self-checking bench for number_value_generator. A draw-level
//               model schedules every digit write from the LFSR sequence and
//               a compare process checks all outputs on each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_number_value_generator;

    localparam int NS = 12;
`ifdef NUMGEN_UNIQUE_EN
    localparam bit UNIQ = 1'b1;
`else
    localparam bit UNIQ = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                refreshReq;
    logic                hitValid;
    logic [3:0]          hitIndex;
    logic [NS-1:0][3:0]  digits;
    logic                digitsValid;
    logic                busy;
    logic                hitDropped;

    number_value_generator #(
        .NUM_SLOTS (12),
        .MAX_DIGIT (9),
        .LFSR_SEED (16'hACE1),
        .MAX_RETRY (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .refreshReq  (refreshReq),
        .hitValid    (hitValid),
        .hitIndex    (hitIndex),
        .digits      (digits),
        .digitsValid (digitsValid),
        .busy        (busy),
        .hitDropped  (hitDropped)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: each fill is expanded into a list of timed writes
    // ------------------------------------------------------------------
    typedef struct {
        int         at;
        int         slot;
        logic [3:0] val;
    } wr_t;

    wr_t         sched[$];
    int          cyc;
    logic [15:0] m_lfsr;
    logic [3:0]  exp_digits [NS];
    bit          fill_fb    [NS];
    bit          exp_valid, exp_busy, exp_drop;
    bit          job_on, job_full;
    int          job_end;
    bit          p_ref, p_hit;
    int          p_idx;

    function automatic logic [15:0] nxt(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // One slot: try successive LFSR values until one is legal or the
    // eighth attempt forces the masked fallback.
    task automatic draw(input logic [15:0] l0, input logic [3:0] prev,
                        output logic [3:0] v, output int n,
                        output logic [15:0] l1, output bit fb);
        logic [15:0] l;
        logic [3:0]  c;
        bit          done;
        l    = l0;
        done = 1'b0;
        fb   = 1'b0;
        v    = 4'd0;
        n    = 0;
        for (int t = 0; t <= 7 && !done; t++) begin
            c = l[3:0];
            if (t == 7) begin
                v = c & 4'h7; fb = 1'b1; n = t + 1; done = 1'b1;
            end else if (c <= 4'd9 && (!UNIQ || c != prev)) begin
                v = c; n = t + 1; done = 1'b1;
            end
            l = nxt(l);
        end
        l1 = l;
    endtask

    task automatic start_job(input bit full, input int slot, input int first_at, input logic [15:0] l0);
        logic [15:0] l;
        logic [3:0]  prev, v;
        int          n, at, s, cnt;
        bit          fb;
        l    = l0;
        at   = first_at;
        s    = full ? 0 : slot;
        cnt  = full ? NS : 1;
        prev = exp_digits[(s + NS - 1) % NS];
        for (int k = 0; k < cnt; k++) begin
            draw(l, prev, v, n, l, fb);
            sched.push_back('{at + n - 1, s + k, v});
            if (full) fill_fb[s + k] = fb;
            job_end = at + n - 1;
            at      = at + n;
            prev    = v;
        end
        job_on   = 1'b1;
        job_full = full;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc       = 0;
            m_lfsr    = 16'hACE1;
            for (int i = 0; i < NS; i++) exp_digits[i] = 4'd0;
            exp_valid = 1'b0;
            exp_drop  = 1'b0;
            p_ref     = 1'b0;
            p_hit     = 1'b0;
            p_idx     = 0;
            sched.delete();
            start_job(1'b1, 0, 1, 16'hACE1);
            exp_busy  = 1'b1;
        end else begin
            bit was_busy, was_full, hv, drop;
            int s;
            cyc++;
            was_busy = job_on;
            was_full = job_full;
            drop     = 1'b0;
            hv       = hitValid && (int'(hitIndex) < NS);
            while (sched.size() > 0 && sched[0].at == cyc) begin
                exp_digits[sched[0].slot] = sched[0].val;
                void'(sched.pop_front());
            end
            if (job_on && cyc == job_end) begin
                job_on = 1'b0;
                if (job_full) exp_valid = 1'b1;
            end
            if (was_busy) begin
                if (!was_full) begin
                    if (refreshReq) p_ref = 1'b1;
                    else if (hv) begin
                        drop  = p_hit;
                        p_hit = 1'b1;
                        p_idx = int'(hitIndex);
                    end
                end
            end else begin
                if (p_ref || refreshReq) begin
                    p_ref = 1'b0; p_hit = 1'b0; exp_valid = 1'b0;
                    start_job(1'b1, 0, cyc + 1, nxt(m_lfsr));
                end else if (p_hit) begin
                    s = p_idx;
                    if (hv) p_idx = int'(hitIndex);
                    else    p_hit = 1'b0;
                    start_job(1'b0, s, cyc + 1, nxt(m_lfsr));
                end else if (hv) begin
                    start_job(1'b0, int'(hitIndex), cyc + 1, nxt(m_lfsr));
                end
            end
            exp_drop = drop;
            exp_busy = job_on;
            m_lfsr   = nxt(m_lfsr);
        end
    end

    // ------------------------------------------------------------------
    // Compare process and hitDropped counter
    // ------------------------------------------------------------------
    int drop_cnt = 0;

    always @(negedge clk) begin
        logic [NS-1:0][3:0] ev;
        if (hitDropped) drop_cnt++;
        if (chk_en) begin
            for (int i = 0; i < NS; i++) ev[i] = exp_digits[i];
            chk("digits",      64'(digits),      64'(ev));
            chk("digitsValid", 64'(digitsValid), 64'(exp_valid));
            chk("busy",        64'(busy),        64'(exp_busy));
            chk("hitDropped",  64'(hitDropped),  64'(exp_drop));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int bound, output int n);
        n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk(name, 64'(busy), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          lit [7];
        logic [3:0]  snap [NS];
        logic [3:0]  first [NS];
        logic [15:0] nl;
        int          g;
        bit          same;

        lit = '{1, 0, 8, 7, 3, 9, 4};
        reset = 1'b0; refreshReq = 1'b0; hitValid = 1'b0; hitIndex = 4'd0;
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;

        // Reset values
        chk("rst_busy",   64'(busy),        64'(1));
        chk("rst_valid",  64'(digitsValid), 64'(0));
        chk("rst_digits", 64'(digits),      64'(0));
        chk("rst_drop",   64'(hitDropped),  64'(0));
        repeat (3) tick();
        reset = 1'b0;

        // Automatic fill after reset
        wait_idle("fill0_done", 120, n);
        chk("fill0_within_96", 64'(n <= 96), 64'(1));
        chk("fill0_valid", 64'(digitsValid), 64'(1));
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("lit_dut_d%0d", i),   64'(digits[i]),     64'(lit[i]));
            chk($sformatf("lit_model_d%0d", i), 64'(exp_digits[i]), 64'(lit[i]));
        end
        for (int i = 0; i < NS; i++) first[i] = exp_digits[i];
        repeat (3) tick();

        // Single re-roll of slot 5
        for (int i = 0; i < NS; i++) snap[i] = exp_digits[i];
        hitValid = 1'b1; hitIndex = 4'd5;
        tick();
        hitValid = 1'b0;
        chk("hit5_busy", 64'(busy), 64'(1));
        wait_idle("hit5_done", 20, n);
        chk("hit5_within_8", 64'(n <= 8), 64'(1));
        same = 1'b1;
        for (int i = 0; i < NS; i++) if (i != 5 && digits[i] != snap[i]) same = 1'b0;
        chk("hit5_others_kept", 64'(same), 64'(1));
        chk("hit5_valid", 64'(digitsValid), 64'(1));

        // Out-of-range indices are ignored
        for (int i = 0; i < NS; i++) snap[i] = exp_digits[i];
        hitValid = 1'b1; hitIndex = 4'd12;
        tick();
        hitIndex = 4'd15;
        tick();
        hitValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("oor_busy", 64'(busy), 64'(0));
            tick();
        end
        same = 1'b1;
        for (int i = 0; i < NS; i++) if (digits[i] != snap[i]) same = 1'b0;
        chk("oor_digits_kept", 64'(same), 64'(1));

        // Hits on 7 then 9 during a FILL_ONE of slot 2. Launch when the
        // first draw for slot 2 is sure to be rejected so both land in FILL_ONE.
        g  = 0;
        nl = nxt(m_lfsr);
        while (nl[3:0] <= 4'd9 && g < 200) begin
            tick();
            g++;
            nl = nxt(m_lfsr);
        end
        chk("drop_window_found", 64'(g < 200), 64'(1));
        for (int i = 0; i < NS; i++) snap[i] = exp_digits[i];
        drop_cnt = 0;
        hitValid = 1'b1; hitIndex = 4'd2;
        tick();
        hitIndex = 4'd7;
        tick();
        hitIndex = 4'd9;
        tick();
        hitValid = 1'b0;
        wait_idle("slot2_done", 20, n);
        tick();
        chk("slot9_started", 64'(busy), 64'(1));
        wait_idle("slot9_done", 20, n);
        chk("drop_count", 64'(drop_cnt), 64'(1));
        chk("slot7_kept", 64'(digits[7]), 64'(snap[7]));
        repeat (2) tick();

        // Simultaneous refresh and hit: refresh wins, no drop
        drop_cnt = 0;
        refreshReq = 1'b1; hitValid = 1'b1; hitIndex = 4'd3;
        tick();
        refreshReq = 1'b0; hitValid = 1'b0;
        chk("both_busy",  64'(busy),        64'(1));
        chk("both_valid", 64'(digitsValid), 64'(0));
        chk("both_drop",  64'(hitDropped),  64'(0));
        wait_idle("both_done", 120, n);
        chk("both_drop_count", 64'(drop_cnt), 64'(0));
        repeat (2) tick();

        // Reset in the middle of a fill, then compare the refill
        refreshReq = 1'b1;
        tick();
        refreshReq = 1'b0;
        for (int c = 0; c < 19 && (job_end - cyc) > 2; c++) tick();
        chk("midfill_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        chk("rst2_digits", 64'(digits),      64'(0));
        chk("rst2_valid",  64'(digitsValid), 64'(0));
        chk("rst2_busy",   64'(busy),        64'(1));
        chk("rst2_drop",   64'(hitDropped),  64'(0));
        repeat (2) tick();
        reset = 1'b0;
        wait_idle("refill_done", 120, n);
        for (int i = 0; i < NS; i++)
            chk($sformatf("refill_d%0d", i), 64'(digits[i]), 64'(first[i]));
`ifdef NUMGEN_UNIQUE_EN
        for (int i = 1; i < NS; i++)
            if (!fill_fb[i])
                chk($sformatf("unique_d%0d", i), 64'(digits[i] != digits[i-1]), 64'(1));
`endif
        repeat (2) tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
